// File: rtl/impctl_pkg.sv
// Shared definitions for the impedance-calibration (impctl) stages.
package impctl_pkg;

    typedef enum logic {
        ACQUIRE = 1'b0,
        TRACK   = 1'b1
    } state_t;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    localparam logic [7:0] CODE_INIT_DFLT = 8'h80;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/impctl_sync2.sv
// Two-flop synchronizer with synchronous active-high clear, for async inputs into l2clk.
module impctl_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/impctl_dtl_updn_ctrl.sv
// DTL impedance calibration: filters comparator decisions on slow-clock ticks,
// steps a saturating drive-strength code, and declares lock when the code dithers.
module impctl_dtl_updn_ctrl
    import impctl_pkg::*;
#(
    parameter int unsigned        CODE_W    = 8,
    parameter logic [CODE_W-1:0]  CODE_INIT = CODE_W'(CODE_INIT_DFLT),
    parameter int unsigned        FILT_N    = 4,
    parameter int unsigned        LOCK_N    = 3,
    parameter int unsigned        LOSE_N    = 8
) (
    input  logic              l2clk,
    input  logic              global_reset,
    input  logic              sclk,
    input  logic              comp_hi,
    input  logic              hold,
    input  logic              recal,
    output logic [CODE_W-1:0] code,
    output logic              code_upd,
    output logic              locked
);

    localparam int unsigned CNT_W = $clog2(max3(FILT_N, LOCK_N, LOSE_N)) + 1;

    logic             comp_s;
    logic             sclk_d;
    state_t           state;
    logic             run_dir;
    logic [CNT_W-1:0] run_cnt;
    logic [CNT_W-1:0] rev_cnt;
    logic [CNT_W-1:0] same_cnt;
    logic             last_step_dir;
    logic             has_last;

    logic              tick_en;
    logic [CNT_W-1:0]  run_cnt_nx;
    logic              step;
    logic              step_dir;
    logic              sat;
    logic [CODE_W-1:0] code_nx;
    logic              is_rev;
    logic [CNT_W-1:0]  rev_cnt_nx;
    logic [CNT_W-1:0]  same_cnt_nx;

    impctl_sync2 u_comp_sync (
        .clk (l2clk),
        .rst (global_reset),
        .d   (comp_hi),
        .q   (comp_s)
    );

    // Tick detect, decision filter and step arithmetic.
    always_comb begin
        tick_en     = sclk & ~sclk_d & ~hold;
        run_cnt_nx  = (comp_s == run_dir) ? run_cnt + CNT_W'(1) : CNT_W'(1);
        step        = tick_en && (run_cnt_nx == CNT_W'(FILT_N));
        step_dir    = comp_s;
        sat         = (step_dir == DIR_UP) ? (code == '1) : (code == '0);
        code_nx     = (step_dir == DIR_UP) ? code + CODE_W'(1) : code - CODE_W'(1);
        is_rev      = has_last && (step_dir != last_step_dir);
        rev_cnt_nx  = rev_cnt + CNT_W'(1);
        same_cnt_nx = (has_last && (step_dir == last_step_dir)) ? same_cnt + CNT_W'(1)
                                                                : CNT_W'(1);
    end

    always_ff @(posedge l2clk) begin
        if (global_reset) begin
            sclk_d        <= 1'b0;
            code          <= CODE_INIT;
            code_upd      <= 1'b0;
            locked        <= 1'b0;
            state         <= ACQUIRE;
            run_dir       <= DIR_DN;
            run_cnt       <= '0;
            rev_cnt       <= '0;
            same_cnt      <= '0;
            last_step_dir <= DIR_DN;
            has_last      <= 1'b0;
        end else begin
            sclk_d   <= sclk;
            code_upd <= 1'b0;
            if (recal) begin
                code          <= CODE_INIT;
                locked        <= 1'b0;
                state         <= ACQUIRE;
                run_dir       <= DIR_DN;
                run_cnt       <= '0;
                rev_cnt       <= '0;
                same_cnt      <= '0;
                last_step_dir <= DIR_DN;
                has_last      <= 1'b0;
            end else if (tick_en) begin
                run_dir <= comp_s;
                if (step) begin
                    run_cnt       <= '0;
                    last_step_dir <= step_dir;
                    has_last      <= 1'b1;
                    // A saturated step still feeds the lock logic below.
                    if (!sat) begin
                        code     <= code_nx;
                        code_upd <= 1'b1;
                    end
                    case (state)
                        ACQUIRE: begin
                            if (is_rev) begin
                                rev_cnt <= rev_cnt_nx;
                                if (rev_cnt_nx == CNT_W'(LOCK_N)) begin
                                    state    <= TRACK;
                                    locked   <= 1'b1;
                                    same_cnt <= '0;
                                end
                            end
                        end
                        TRACK: begin
                            if (same_cnt_nx == CNT_W'(LOSE_N)) begin
                                state    <= ACQUIRE;
                                locked   <= 1'b0;
                                rev_cnt  <= '0;
                                same_cnt <= '0;
                            end else begin
                                same_cnt <= same_cnt_nx;
                            end
                        end
                        default: state <= ACQUIRE;
                    endcase
                end else begin
                    run_cnt <= run_cnt_nx;
                end
            end
        end
    end

endmodule
